multi_cycle_controller: RTL and testbench
=========================================

# multi_cycle_controller

Main control unit for the multi-cycle RV32I core. A Moore state machine sequences the shared datapath: one memory for instructions and data, one ALU, and the PC, instruction, data and ALUOut registers. It decodes `OP`/`funct3`/`funct7`/`Zero` into per-cycle mux selects, write enables and ALU operation. Supported instructions: `lw`, `sw`, R-type and I-type ALU ops (`add`/`sub`/`and`/`or`/`slt`), `beq`, `bne`, `jal`. Any other opcode parks the core in a sticky error state.

## Interface
- No parameters.
- `CLK` in 1: single system clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `OP` in 7: `Instr[6:0]`.
- `funct3` in 3: `Instr[14:12]`.
- `funct7` in 1: `Instr[30]`.
- `Zero` in 1: ALU zero flag, combinational from the current cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select, 0 = PC, 1 = Result.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register and OldPC enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = A.
- `ALUSrcB` out 2: 00 = WriteData, 01 = ImmExt, 10 = constant 4.
- `ImmSrc` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `IllegalInstr` out 1: sticky; set on entry to ERROR.
- `InstrDone` out 1: one-cycle pulse in the last state of each retired instruction.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, ERROR. Encoding is free; the state register is not exposed.
- Internal `ALUOp`: 00 = add, 01 = sub, 10 = decode from funct fields.
- ALU decode for `ALUOp` = 10, keyed on `funct3`:
  - 000: sub if `OP[5] & funct7`, else add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other `funct3` with `OP` = R or I: ERROR, detected in DECODE.
- `ImmSrc` is combinational from `OP`: `lw`/I-ALU = 00, `sw` = 01, branch = 10, `jal` = 11. Unknown opcode gives 00.
- Per-state outputs. Any enable not listed is 0; unlisted selects are don't-care, and the implementation drives 00.
  - FETCH: `AdrSrc`=0, `IRWrite`=1, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `PCWrite`=1. Next: DECODE.
  - DECODE: `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (branch target into ALUOut). Next by `OP`:
    - 0000011 or 0100011: MEMADR.
    - 0110011: EXECUTER.
    - 0010011: EXECUTEI.
    - 1100011 with `funct3` 000 or 001: BRANCH.
    - 1101111: JAL.
    - Otherwise: ERROR.
  - MEMADR: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. Next: MEMREAD if `OP[5]`=0, else MEMWRITE.
  - MEMREAD: `ResultSrc`=00, `AdrSrc`=1. Next: MEMWB.
  - MEMWB: `ResultSrc`=01, `RegWrite`=1, `InstrDone`=1. Next: FETCH.
  - MEMWRITE: `ResultSrc`=00, `AdrSrc`=1, `MemWrite`=1, `InstrDone`=1. Next: FETCH.
  - EXECUTER: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Next: ALUWB.
  - EXECUTEI: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10. Next: ALUWB.
  - ALUWB: `ResultSrc`=00, `RegWrite`=1, `InstrDone`=1. Next: FETCH.
  - JAL: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1. Next: ALUWB.
  - BRANCH: `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00, `InstrDone`=1. `PCWrite` = `Zero` XOR `funct3[0]` (`beq` taken on `Zero`, `bne` on `!Zero`). Next: FETCH.
  - ERROR: all enables 0, `IllegalInstr`=1. Stays in ERROR until reset.

## Timing
- Reset asserted (`RESET`=0):
  - State forced to FETCH asynchronously.
  - `IllegalInstr` cleared.
  - `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `InstrDone` gated to 0 combinationally while reset is held.
  - Selects show FETCH values.
- First rising edge after release: FETCH executes and the instruction is latched.
- Cycles per instruction, counting FETCH: `lw` 5, `sw` 4, R 4, I 4, `beq`/`bne` 3, `jal` 4.
- All outputs are pure functions of state, `OP` and `funct3`/`funct7`, except BRANCH `PCWrite`, which also depends on the same-cycle `Zero`.
- Reset mid-instruction abandons it: no `RegWrite`/`MemWrite` pulse after reset asserts, and execution restarts at FETCH.
- `IllegalInstr` rises in the cycle after DECODE. It holds through any `OP` change and clears only on reset.

## Test plan
- Reset held 3 cycles, then released; next instruction `add x3,x1,x2` (0x002081B3) -> states FETCH, DECODE, EXECUTER, ALUWB. `ALUControl`=000 in EXECUTER. `RegWrite`=1 only in cycle 4.
- `sub` (funct7=1, funct3=000, OP=0110011) -> `ALUControl`=001. `addi` with funct7 bit set -> 000. `slt` -> 101. `or` -> 011. `and` -> 010.
- `lw` -> 5 cycles. `AdrSrc`=1 in MEMREAD. `ResultSrc`=01 and `RegWrite` in MEMWB. `sw` -> 4 cycles, `MemWrite` high exactly one cycle.
- `beq` with `Zero`=1 -> `PCWrite`=1 in BRANCH. `beq` with `Zero`=0 -> 0. `bne` with `Zero`=0 -> 1. 3 cycles each.
- `jal` -> `ImmSrc`=11 in DECODE. `PCWrite` in JAL. `RegWrite` in ALUWB. 4 cycles.
- OP=1111111 -> ERROR after DECODE, `IllegalInstr`=1, no enables for 10 cycles. Asserting `RESET` during MEMREAD -> no `RegWrite`; restart at FETCH.

Source files
------------

// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle RV32I controller and its datapath.
// The controller connects through the master modport, the datapath through slave.
interface multi_cycle_controller_if;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       IllegalInstr;
  logic       InstrDone;

  modport master (
    input  OP, funct3, funct7, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr, InstrDone
  );

  modport slave (
    output OP, funct3, funct7, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr, InstrDone
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle RV32I core: sequences the shared
// memory/ALU datapath for lw, sw, R/I ALU ops, beq, bne and jal, and parks
// in a sticky ERROR state on any unsupported instruction.
module multi_cycle_controller (
  input  logic                           CLK,
  input  logic                           RESET,
  multi_cycle_controller_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ERROR
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state;
  state_t     nxt;
  logic       ill_q;
  logic [1:0] aluop;
  logic       alu_f3_ok;
  logic       pcw_raw;
  logic       irw_raw;
  logic       regw_raw;
  logic       memw_raw;
  logic       done_raw;

  // State register, forced to FETCH asynchronously by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_FETCH;
    else        state <= nxt;
  end

  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                ill_q <= 1'b0;
    else if (nxt == S_ERROR)   ill_q <= 1'b1;
  end

  // funct3 values the ALU decoder can handle for R/I instructions.
  always_comb begin
    alu_f3_ok = 1'b0;
    case (bus.funct3)
      3'b000, 3'b010, 3'b110, 3'b111: alu_f3_ok = 1'b1;
      default:                        alu_f3_ok = 1'b0;
    endcase
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    nxt           = state;
    pcw_raw       = 1'b0;
    irw_raw       = 1'b0;
    regw_raw      = 1'b0;
    memw_raw      = 1'b0;
    done_raw      = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    aluop         = 2'b00;
    case (state)
      S_FETCH: begin
        irw_raw       = 1'b1;
        pcw_raw       = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        nxt           = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (bus.OP)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = alu_f3_ok ? S_EXECUTER : S_ERROR;
          OP_I:         nxt = alu_f3_ok ? S_EXECUTEI : S_ERROR;
          OP_BR:        nxt = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_ERROR;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        nxt         = bus.OP[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        nxt        = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        regw_raw      = 1'b1;
        done_raw      = 1'b1;
        nxt           = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        memw_raw   = 1'b1;
        done_raw   = 1'b1;
        nxt        = S_FETCH;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = 2'b10;
        aluop       = 2'b10;
        nxt         = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        aluop       = 2'b10;
        nxt         = S_ALUWB;
      end
      S_ALUWB: begin
        regw_raw = 1'b1;
        done_raw = 1'b1;
        nxt      = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        pcw_raw     = 1'b1;
        nxt         = S_ALUWB;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 2'b10;
        aluop       = 2'b01;
        // funct3[0] inverts the condition: beq takes on Zero, bne on !Zero.
        pcw_raw     = bus.Zero ^ bus.funct3[0];
        done_raw    = 1'b1;
        nxt         = S_FETCH;
      end
      S_ERROR: nxt = S_ERROR;
      default: nxt = S_FETCH;
    endcase
  end

  // ALU operation from ALUOp and the instruction funct fields.
  always_comb begin
    bus.ALUControl = 3'b000;
    case (aluop)
      2'b00: bus.ALUControl = 3'b000;
      2'b01: bus.ALUControl = 3'b001;
      default: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.OP[5] & bus.funct7) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  // Immediate format selected directly from the opcode.
  always_comb begin
    bus.ImmSrc = 2'b00;
    case (bus.OP)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BR:   bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Write enables and the retire pulse are suppressed while reset is held.
  always_comb begin
    bus.PCWrite      = pcw_raw  & RESET;
    bus.IRWrite      = irw_raw  & RESET;
    bus.RegWrite     = regw_raw & RESET;
    bus.MemWrite     = memw_raw & RESET;
    bus.InstrDone    = done_raw & RESET;
    bus.IllegalInstr = ill_q;
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller. Outputs are packed
// into one vector and compared per cycle against hand-written per-state values.
module tb_multi_cycle_controller;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  multi_cycle_controller_if bus ();

  multi_cycle_controller dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  localparam int FE = 0, DE = 1, MA = 2, MR = 3, MW = 4, MX = 5,
                 ER = 6, EI = 7, WB = 8, BR = 9, JL = 10, EE = 11;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,
  //  ImmSrc,ALUControl,IllegalInstr,InstrDone}
  function automatic logic [17:0] obs();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
            bus.ALUControl, bus.IllegalInstr, bus.InstrDone};
  endfunction

  // Hand-written control table for each state.
  function automatic logic [17:0] exp_of(int s, logic [1:0] imm, logic [2:0] aluc, logic pcw);
    case (s)
      FE: return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0};
      DE: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0, 1'b0};
      MA: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 1'b0, 1'b0};
      MR: return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0, 1'b0};
      MW: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 1'b0, 1'b1};
      MX: return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0, 1'b1};
      ER: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, aluc,   1'b0, 1'b0};
      EI: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, imm, aluc,   1'b0, 1'b0};
      WB: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b0, 1'b1};
      BR: return {pcw,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, imm, 3'b001, 1'b0, 1'b1};
      JL: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 1'b0, 1'b0};
      EE: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1, 1'b0};
      default: return '0;
    endcase
  endfunction

  // Reset view: FETCH selects with every enable gated off.
  function automatic logic [17:0] rst_vec(logic [1:0] imm);
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0, 1'b0};
  endfunction

  task automatic set_instr(logic [6:0] op, logic [2:0] f3, logic f7);
    bus.OP     = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  task automatic test_reset;
    logic [17:0] got;
    RESET = 1'b0;
    bus.Zero = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      #2;
      got = obs();
      checks++;
      if (got !== rst_vec(2'b00)) begin
        errors++;
        $display("FAIL reset_c%0d got=%h want=%h", i, got, rst_vec(2'b00));
      end
      @(posedge CLK); #1;
    end
    RESET = 1'b1;
  endtask

  task automatic test_add;
    int seq[4] = '{FE, DE, ER, WB};
    logic [17:0] got, want;
    set_instr(7'b0110011, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      got  = obs();
      want = exp_of(seq[i], 2'b00, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL add_c%0d got=%h want=%h", i, got, want);
      end
      @(posedge CLK); #1;
    end
    #2;
    got = obs();
    checks++;
    if (got !== exp_of(FE, 2'b00, 3'b000, 1'b0)) begin
      errors++;
      $display("FAIL add_refetch got=%h want=%h", got, exp_of(FE, 2'b00, 3'b000, 1'b0));
    end
  endtask

  task automatic test_alu_ops;
    // op, funct3, funct7, execute state, expected ALUControl
    logic [6:0] ops [5] = '{7'b0110011, 7'b0010011, 7'b0110011, 7'b0010011, 7'b0110011};
    logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111};
    logic       f7s [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int         exs [5] = '{ER, EI, ER, EI, ER};
    logic [2:0] acs [5] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010};
    logic [17:0] got, want;
    int seq[4];
    for (int k = 0; k < 5; k++) begin
      set_instr(ops[k], f3s[k], f7s[k]);
      seq = '{FE, DE, exs[k], WB};
      for (int i = 0; i < 4; i++) begin
        #2;
        got  = obs();
        want = exp_of(seq[i], 2'b00, acs[k], 1'b0);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL alu%0d_c%0d got=%h want=%h", k, i, got, want);
        end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_mem;
    int lw_seq[5] = '{FE, DE, MA, MR, MW};
    int sw_seq[4] = '{FE, DE, MA, MX};
    logic [17:0] got, want;
    set_instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #2;
      got  = obs();
      want = exp_of(lw_seq[i], 2'b00, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL lw_c%0d got=%h want=%h", i, got, want);
      end
      @(posedge CLK); #1;
    end
    set_instr(7'b0100011, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      got  = obs();
      want = exp_of(sw_seq[i], 2'b01, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sw_c%0d got=%h want=%h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch;
    // beq Zero=1 taken, beq Zero=0 not taken, bne Zero=0 taken, bne Zero=1 not taken
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int seq[3] = '{FE, DE, BR};
    logic [17:0] got, want;
    for (int k = 0; k < 4; k++) begin
      set_instr(7'b1100011, f3s[k], 1'b0);
      bus.Zero = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (i == 2) bus.Zero = zs[k];
        #2;
        got  = obs();
        want = exp_of(seq[i], 2'b10, 3'b000, tk[k]);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL br%0d_c%0d got=%h want=%h", k, i, got, want);
        end
        @(posedge CLK); #1;
      end
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_jal;
    int seq[4] = '{FE, DE, JL, WB};
    logic [17:0] got, want;
    set_instr(7'b1101111, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      got  = obs();
      want = exp_of(seq[i], 2'b11, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL jal_c%0d got=%h want=%h", i, got, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_illegal;
    logic [17:0] got, want;
    set_instr(7'b1111111, 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      // Opcode change while parked must not release the error state.
      if (i == 6) set_instr(7'b0110011, 3'b000, 1'b0);
      #2;
      got  = obs();
      want = exp_of((i == 0) ? FE : (i == 1) ? DE : EE, 2'b00, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL illegal_c%0d got=%h want=%h", i, got, want);
      end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    #2;
    got = obs();
    checks++;
    if (got !== rst_vec(2'b00)) begin
      errors++;
      $display("FAIL illegal_clear got=%h want=%h", got, rst_vec(2'b00));
    end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_reset_midinstr;
    int seq[4] = '{FE, DE, MA, MR};
    logic [17:0] got, want;
    set_instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      got  = obs();
      want = exp_of(seq[i], 2'b00, 3'b000, 1'b0);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL midrst_c%0d got=%h want=%h", i, got, want);
      end
      if (i < 3) begin
        @(posedge CLK); #1;
      end
    end
    #1;
    RESET = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== rst_vec(2'b00)) begin
      errors++;
      $display("FAIL midrst_assert got=%h want=%h", got, rst_vec(2'b00));
    end
    @(posedge CLK); #2;
    got = obs();
    checks++;
    if (got !== rst_vec(2'b00)) begin
      errors++;
      $display("FAIL midrst_hold got=%h want=%h", got, rst_vec(2'b00));
    end
    RESET = 1'b1;
    #1;
    got = obs();
    checks++;
    if (got !== exp_of(FE, 2'b00, 3'b000, 1'b0)) begin
      errors++;
      $display("FAIL midrst_fetch got=%h want=%h", got, exp_of(FE, 2'b00, 3'b000, 1'b0));
    end
    @(posedge CLK); #3;
    got = obs();
    checks++;
    if (got !== exp_of(DE, 2'b00, 3'b000, 1'b0)) begin
      errors++;
      $display("FAIL midrst_decode got=%h want=%h", got, exp_of(DE, 2'b00, 3'b000, 1'b0));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_mem();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_midinstr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
